instruction_fetch_unit: RTL

Program-counter and instruction-fetch stage directly upstream of the main control decoder. It holds the PC, fetches one 32-bit instruction per step from instruction memory over a req/ack handshake, and presents it (opcode to the decoder, fields to the datapath) for one execute cycle. It then consumes the decoder's BranchEQ/BranchNE/Jump outputs, the ALU Zero flag and a jump-register request to select the next PC.

---
 rtl/instruction_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// instruction_fetch_unit
//
// Program counter and instruction-fetch stage sitting in front of the main
// control decoder. Each instruction is fetched over a req/ack handshake,
// held in a register for one (or more, if stalled) execute cycles, and the
// decoder/ALU results of that execute cycle choose the next PC.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   imem_req/imem_addr    fetch request (held until ack) and fetch address
//   imem_ack/imem_rdata   memory acknowledge with same-cycle read data
//   instr/instr_valid     registered current instruction, valid in EXEC
//   pc/pc_plus4           address of current instruction and pc + 4
//   BranchEQ/BranchNE     decoder branch outputs for the current instruction
//   Jump/JR               decoder jump and jump-register requests
//   Zero                  ALU zero flag for the current instruction
//   rs_data               register-file rs value (JR target)
//   stall                 hold the current instruction in EXEC
//   retired               count of completed instructions (wraps)
//   pc_misaligned         sticky flag: a JR target was not word-aligned
// ============================================================================
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        BranchEQ,
    input  logic        BranchNE,
    input  logic        Jump,
    input  logic        JR,
    input  logic        Zero,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic [31:0] retired,
    output logic        pc_misaligned
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic        branch_taken;
    logic [31:0] next_pc;

    // ------------------------------------------------------------------------
    // Next-PC selection (only consumed on the final, non-stalled EXEC cycle)
    // ------------------------------------------------------------------------
    assign pc_plus4_w   = pc_q + 32'd4;
    assign branch_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    // Both branch kinds high at once means "taken if either condition holds".
    assign branch_taken = (BranchEQ & Zero) | (BranchNE & ~Zero);

    always_comb begin
        next_pc = pc_plus4_w;
        if (JR) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (Jump) begin
            next_pc = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4_w + branch_off;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and datapath register updates
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        retired_d    = retired_q;
        misaligned_d = misaligned_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // imem_ack only has meaning here; it is ignored in every other state.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    if (JR && (rs_data[1:0] != 2'b00)) begin
                        misaligned_d = 1'b1;
                    end
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset is asynchronous so an in-flight request drops immediately and a
    // coincident ack can never be latched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0000_0000;
            retired_q    <= 32'h0000_0000;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            misaligned_q <= misaligned_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req      = (state_q == REQ);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == EXEC);
    assign pc            = pc_q;
    assign pc_plus4      = pc_plus4_w;
    assign retired       = retired_q;
    assign pc_misaligned = misaligned_q;

endmodule
